// File: rtl/regfile_access_seq_pkg.sv
// Shared definitions for the register-file access sequencer.
//   - MODE_* : per-port access mode encoding (none / low byte / high byte / word)
//   - state_t: sequencer FSM states
//   - cs_t   : strobe triple {h, l, 16} as seen by the register file
//   - mode_to_cs(): maps an access mode to its single strobe
package regfile_access_seq_pkg;

   localparam logic [1:0] MODE_NONE = 2'b00;
   localparam logic [1:0] MODE_LOW  = 2'b01;
   localparam logic [1:0] MODE_HIGH = 2'b10;
   localparam logic [1:0] MODE_WORD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPTURE,
      ST_OPS,
      ST_RESULT,
      ST_WRITE
   } state_t;

   typedef struct packed {
      logic h;
      logic l;
      logic w16;
   } cs_t;

   // Exactly one strobe per mode. The register file resolves multiple
   // strobes by priority, so emitting more than one would silently change
   // the access width; this mapping never does.
   function automatic cs_t mode_to_cs(input logic [1:0] mode);
      cs_t cs;
      cs = '0;
      case (mode)
         MODE_LOW:  cs.l   = 1'b1;
         MODE_HIGH: cs.h   = 1'b1;
         MODE_WORD: cs.w16 = 1'b1;
         default:   cs     = '0;
      endcase
      return cs;
   endfunction

endpackage

// File: rtl/regfile_access_seq_strobe_dec.sv
// Combinational strobe decoder: (enable, mode) -> one-hot-or-zero strobe triple.
// Ports:
//   en    in  1  decode enable (sequencer is in the owning state)
//   mode  in  2  access mode (MODE_* encoding)
//   cs_h  out 1  high-byte strobe
//   cs_l  out 1  low-byte strobe
//   cs_16 out 1  word strobe
module regfile_strobe_dec
   import regfile_access_seq_pkg::*;
(
   input  logic       en,
   input  logic [1:0] mode,
   output logic       cs_h,
   output logic       cs_l,
   output logic       cs_16
);

   cs_t cs;

   // NOTE: every combinational output gets a default before any branch, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cs = '0;
      if (en) cs = mode_to_cs(mode);
   end

   assign cs_h  = cs.h;
   assign cs_l  = cs.l;
   assign cs_16 = cs.w16;

endmodule

// File: rtl/regfile_access_seq.sv
// Register-file access sequencer (initiator side of a dual-read/single-write
// register file). Takes one request, reads up to two operands, hands them to
// the ALU, takes the result and writes it back through port 1.
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   src1, src2, mode1, mode2      source indices and read modes
//   dst, wmode                    destination index and write mode
//   op_valid/op_ready, op_a/op_b  operand handshake to the ALU
//   res_valid/res_ready, res_data result handshake from the ALU
//   done                          one-cycle completion strobe
//   num1, num2                    register file indices
//   bus_in                        register file write data
//   bus_out1, bus_out2            register file registered read data
//   cs_{h,l,16}_out{1,2}          read strobes; cs_{h,l,16}_in write strobes
module regfile_access_seq
   import regfile_access_seq_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] src2,
   input  logic [1:0]        mode1,
   input  logic [1:0]        mode2,
   input  logic [ADDR_W-1:0] dst,
   input  logic [1:0]        wmode,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [DATA_W-1:0] res_data,
   output logic              done,
   output logic [ADDR_W-1:0] num1,
   output logic [ADDR_W-1:0] num2,
   output logic [DATA_W-1:0] bus_in,
   input  logic [DATA_W-1:0] bus_out1,
   input  logic [DATA_W-1:0] bus_out2,
   output logic              cs_h_out1,
   output logic              cs_l_out1,
   output logic              cs_16_out1,
   output logic              cs_h_out2,
   output logic              cs_l_out2,
   output logic              cs_16_out2,
   output logic              cs_h_in,
   output logic              cs_l_in,
   output logic              cs_16_in
);

   state_t            state, state_nx;

   logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
   logic [1:0]        mode1_q, mode2_q, wmode_q;

   logic              rd_en, wr_en;
   logic              accept, res_fire;

   assign accept   = req_ready & req_valid;
   assign res_fire = res_ready & res_valid;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Next state and all handshake/index outputs. Strobes are decoded from
   // state, never registered, so an asynchronous reset removes them in the
   // same cycle and a write can never be left half-issued.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      op_valid  = 1'b0;
      res_ready = 1'b0;
      done      = 1'b0;
      num1      = '0;
      num2      = '0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;

      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               // Nothing to read: skip the register file round trip.
               if (mode1 == MODE_NONE && mode2 == MODE_NONE) state_nx = ST_OPS;
               else                                         state_nx = ST_READ;
            end
         end
         ST_READ: begin
            num1     = src1_q;
            num2     = src2_q;
            rd_en    = 1'b1;
            state_nx = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // Register file output is registered: indices stay put while
            // the data it launched on the READ edge is sampled.
            num1     = src1_q;
            num2     = src2_q;
            state_nx = ST_OPS;
         end
         ST_OPS: begin
            op_valid = 1'b1;
            if (op_ready) state_nx = ST_RESULT;
         end
         ST_RESULT: begin
            res_ready = 1'b1;
            if (res_valid) begin
               if (wmode_q == MODE_NONE) begin
                  done     = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            num1     = dst_q;
            wr_en    = 1'b1;
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Request fields, operands and write data. Operands are cleared on
   // accept so the no-read path presents zeros; a port whose mode is NONE
   // keeps zero because its bus is not driven by the register file.
   // NOTE: every datapath register has an explicit reset value; there is
   // no storage array here that would make resetting costly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src1_q  <= '0;
         src2_q  <= '0;
         dst_q   <= '0;
         mode1_q <= MODE_NONE;
         mode2_q <= MODE_NONE;
         wmode_q <= MODE_NONE;
         op_a    <= '0;
         op_b    <= '0;
         bus_in  <= '0;
      end else begin
         if (accept) begin
            src1_q  <= src1;
            src2_q  <= src2;
            dst_q   <= dst;
            mode1_q <= mode1;
            mode2_q <= mode2;
            wmode_q <= wmode;
            op_a    <= '0;
            op_b    <= '0;
         end
         if (state == ST_CAPTURE) begin
            op_a <= (mode1_q != MODE_NONE) ? bus_out1 : '0;
            op_b <= (mode2_q != MODE_NONE) ? bus_out2 : '0;
         end
         if (res_fire) bus_in <= res_data;
      end
   end

   regfile_strobe_dec u_dec_rd1 (
      .en    (rd_en),
      .mode  (mode1_q),
      .cs_h  (cs_h_out1),
      .cs_l  (cs_l_out1),
      .cs_16 (cs_16_out1)
   );

   regfile_strobe_dec u_dec_rd2 (
      .en    (rd_en),
      .mode  (mode2_q),
      .cs_h  (cs_h_out2),
      .cs_l  (cs_l_out2),
      .cs_16 (cs_16_out2)
   );

   regfile_strobe_dec u_dec_wr (
      .en    (wr_en),
      .mode  (wmode_q),
      .cs_h  (cs_h_in),
      .cs_l  (cs_l_in),
      .cs_16 (cs_16_in)
   );

endmodule

// File: tb/tb_regfile_access_seq.sv
// Bench for regfile_access_seq: a 4-entry register file model sits on the
// DUT's register-file port, a driver issues requests and plays the ALU, and
// a negedge monitor checks operands against a queue of expected values.
module tb_regfile_access_seq;

   logic        clk, reset;
   logic        req_valid, req_ready;
   logic [1:0]  src1, src2, mode1, mode2, dst, wmode;
   logic        op_valid, op_ready;
   logic [15:0] op_a, op_b;
   logic        res_valid, res_ready;
   logic [15:0] res_data;
   logic        done;
   logic [1:0]  num1, num2;
   logic [15:0] bus_in, bus_out1, bus_out2;
   logic        cs_h_out1, cs_l_out1, cs_16_out1;
   logic        cs_h_out2, cs_l_out2, cs_16_out2;
   logic        cs_h_in, cs_l_in, cs_16_in;

   regfile_access_seq #(.ADDR_W(2), .DATA_W(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .src1(src1), .src2(src2), .mode1(mode1), .mode2(mode2),
      .dst(dst), .wmode(wmode),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .done(done), .num1(num1), .num2(num2), .bus_in(bus_in),
      .bus_out1(bus_out1), .bus_out2(bus_out2),
      .cs_h_out1(cs_h_out1), .cs_l_out1(cs_l_out1), .cs_16_out1(cs_16_out1),
      .cs_h_out2(cs_h_out2), .cs_l_out2(cs_l_out2), .cs_16_out2(cs_16_out2),
      .cs_h_in(cs_h_in), .cs_l_in(cs_l_in), .cs_16_in(cs_16_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- register file model (environment) ----------------
   logic [15:0] rf [4];
   logic        pl_en;
   logic [1:0]  pl_idx;
   logic [15:0] pl_data;

   // Unselected read ports return junk so that sampling a port whose mode
   // is NONE shows up as a wrong operand.
   always @(posedge clk) begin
      if (cs_h_out1)       bus_out1 <= {8'h00, rf[num1][15:8]};
      else if (cs_l_out1)  bus_out1 <= {8'h00, rf[num1][7:0]};
      else if (cs_16_out1) bus_out1 <= rf[num1];
      else                 bus_out1 <= 16'($urandom);
      if (cs_h_out2)       bus_out2 <= {8'h00, rf[num2][15:8]};
      else if (cs_l_out2)  bus_out2 <= {8'h00, rf[num2][7:0]};
      else if (cs_16_out2) bus_out2 <= rf[num2];
      else                 bus_out2 <= 16'($urandom);
      if (pl_en)           rf[pl_idx]       <= pl_data;
      else if (cs_h_in)    rf[num1][15:8]   <= bus_in[7:0];
      else if (cs_l_in)    rf[num1][7:0]    <= bus_in[7:0];
      else if (cs_16_in)   rf[num1]         <= bus_in;
   end

   // ---------------- reference model and scoreboard ----------------
   logic [15:0] ref_regs [4];

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      int          lat;
   } ops_t;
   ops_t exp_ops [$];

   int vectors = 0;
   int miscompares = 0;

   // monitor bookkeeping shared with the driver
   int       cyc = 0, accept_cyc = 0, done_cnt = 0;
   bit       ops_first = 0, res_seen = 0;
   logic [2:0] seen1, seen2, seen_w;
   logic [1:0] cur_src1, cur_src2, cur_dst;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic timeout_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got no response within bound, want a response", name);
   endtask

   function automatic logic [15:0] ref_read(input logic [1:0] idx, input logic [1:0] m);
      case (m)
         2'd1:    return {8'h00, ref_regs[idx][7:0]};
         2'd2:    return {8'h00, ref_regs[idx][15:8]};
         2'd3:    return ref_regs[idx];
         default: return 16'h0000;
      endcase
   endfunction

   task automatic ref_write(input logic [1:0] idx, input logic [1:0] m, input logic [15:0] v);
      case (m)
         2'd1:    ref_regs[idx][7:0]  = v[7:0];
         2'd2:    ref_regs[idx][15:8] = v[7:0];
         2'd3:    ref_regs[idx]       = v;
         default: ;
      endcase
   endtask

   // expected strobe set {h, l, 16} for a mode
   function automatic logic [2:0] exp_mask(input logic [1:0] m);
      case (m)
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         2'd3:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) check($sformatf("%s_r%0d", tag, i), rf[i], ref_regs[i]);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [2:0] p1, p2, pw;
      forever begin
         @(negedge clk);
         if (!reset) begin
            cyc++;
            p1 = {cs_h_out1, cs_l_out1, cs_16_out1};
            p2 = {cs_h_out2, cs_l_out2, cs_16_out2};
            pw = {cs_h_in, cs_l_in, cs_16_in};
            seen1  = seen1 | p1;
            seen2  = seen2 | p2;
            seen_w = seen_w | pw;
            if (req_valid && req_ready) begin
               accept_cyc = cyc;
               ops_first  = 1;
            end
            if (done) done_cnt++;
            if (res_valid && res_ready) res_seen = 1;
            if (|p1) begin
               check("rd1_onehot", $countones(p1), 1);
               check("rd1_num", num1, cur_src1);
            end
            if (|p2) begin
               check("rd2_onehot", $countones(p2), 1);
               check("rd2_num", num2, cur_src2);
            end
            if (|pw) begin
               check("wr_onehot", $countones(pw), 1);
               check("wr_after_result", res_seen, 1);
               check("wr_num1", num1, cur_dst);
            end
            if (op_valid) begin
               if (exp_ops.size() == 0) begin
                  check("ops_unexpected", op_valid, 0);
               end else begin
                  if (ops_first) begin
                     check("op_latency", cyc - accept_cyc, exp_ops[0].lat);
                     ops_first = 0;
                  end
                  check("op_a", op_a, exp_ops[0].a);
                  check("op_b", op_b, exp_ops[0].b);
                  if (op_ready) void'(exp_ops.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic preload(input logic [1:0] i, input logic [15:0] v);
      pl_en = 1'b1; pl_idx = i; pl_data = v;
      @(posedge clk); #1;
      pl_en = 1'b0;
      ref_regs[i] = v;
   endtask

   // Waits for a read (which=1) or write (which=2) strobe, resets the DUT
   // inside that cycle and checks the strobes fall at once.
   task automatic reset_on_strobe(input int which);
      int  n;
      bit  hit;
      n = 0; hit = 0;
      while (!hit && n < 20) begin
         @(negedge clk);
         if (which == 1) hit = |{cs_h_out1, cs_l_out1, cs_16_out1, cs_h_out2, cs_l_out2, cs_16_out2};
         else            hit = |{cs_h_in, cs_l_in, cs_16_in};
         n++;
      end
      if (!hit) timeout_fail("abort_strobe");
      #1 reset = 1'b1;
      #1;
      check("cs_all_in_reset", {cs_h_out1, cs_l_out1, cs_16_out1, cs_h_out2, cs_l_out2,
                                cs_16_out2, cs_h_in, cs_l_in, cs_16_in}, 0);
      check("op_valid_in_reset", op_valid, 0);
      check("done_in_reset", done, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_ops.delete();
      ops_first = 0;
      @(posedge clk); #1;
      check("req_ready_after_reset", req_ready, 1);
      check_regs("abort");
   endtask

   // One request; abort: 0 = run to completion, 1 = reset in READ, 2 = reset in WRITE.
   task automatic run_txn(input logic [1:0] s1, input logic [1:0] m1,
                          input logic [1:0] s2, input logic [1:0] m2,
                          input logic [1:0] d, input logic [1:0] wm,
                          input logic [15:0] res, input int op_dly, input int res_dly,
                          input int abort);
      ops_t e;
      int   n, done0;
      e.a   = ref_read(s1, m1);
      e.b   = ref_read(s2, m2);
      e.lat = (m1 == 2'd0 && m2 == 2'd0) ? 1 : 3;

      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!req_ready) begin timeout_fail("req_ready"); return; end

      cur_src1 = s1; cur_src2 = s2; cur_dst = d;
      seen1 = '0; seen2 = '0; seen_w = '0; res_seen = 0;
      done0 = done_cnt;
      exp_ops.push_back(e);

      req_valid = 1'b1;
      src1 = s1; src2 = s2; mode1 = m1; mode2 = m2; dst = d; wmode = wm;
      @(posedge clk); #1;
      req_valid = 1'b0;
      // fields are only latched on accept; scramble them afterwards
      src1 = 2'($urandom); src2 = 2'($urandom); mode1 = 2'($urandom);
      mode2 = 2'($urandom); dst = 2'($urandom); wmode = 2'($urandom);

      if (abort == 1) begin reset_on_strobe(1); return; end

      n = 0;
      while (!op_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (!op_valid) begin timeout_fail("op_valid"); return; end
      repeat (op_dly) begin
         check("req_ready_busy_ops", req_ready, 0);
         @(posedge clk); #1;
      end
      op_ready = 1'b1;
      @(posedge clk); #1;
      op_ready = 1'b0;

      n = 0;
      while (!res_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!res_ready) begin timeout_fail("res_ready"); return; end
      repeat (res_dly) begin
         check("req_ready_busy_res", req_ready, 0);
         res_data = 16'($urandom);
         @(posedge clk); #1;
      end
      res_valid = 1'b1;
      res_data  = res;
      #4;
      check("done_in_result", done, (wm == 2'd0));
      @(posedge clk); #1;
      res_valid = 1'b0;
      res_data  = 16'($urandom);

      if (abort == 2) begin reset_on_strobe(2); return; end

      n = 0;
      while (done_cnt == done0 && n < 50) begin @(posedge clk); #1; n++; end
      if (done_cnt == done0) begin timeout_fail("done"); return; end
      @(posedge clk); #1;

      ref_write(d, wm, res);
      check("done_pulses", done_cnt - done0, 1);
      check("cs_port1_set", seen1, exp_mask(m1));
      check("cs_port2_set", seen2, exp_mask(m2));
      check("cs_write_set", seen_w, exp_mask(wm));
      check_regs("txn");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      req_valid = 1'b0; op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
      src1 = '0; src2 = '0; mode1 = '0; mode2 = '0; dst = '0; wmode = '0;
      pl_en = 1'b0; pl_idx = '0; pl_data = '0;
      seen1 = '0; seen2 = '0; seen_w = '0;
      cur_src1 = '0; cur_src2 = '0; cur_dst = '0;
      repeat (2) @(posedge clk);
      #1;
      preload(2'd0, 16'h0F0F);
      preload(2'd1, 16'h1234);
      preload(2'd2, 16'hABCD);
      preload(2'd3, 16'h6789);

      // reset values
      check("rst_req_ready", req_ready, 1);
      check("rst_op_valid", op_valid, 0);
      check("rst_res_ready", res_ready, 0);
      check("rst_done", done, 0);
      check("rst_cs", {cs_h_out1, cs_l_out1, cs_16_out1, cs_h_out2, cs_l_out2,
                       cs_16_out2, cs_h_in, cs_l_in, cs_16_in}, 0);
      check("rst_op_a", op_a, 0);
      check("rst_op_b", op_b, 0);
      check("rst_num", {num1, num2}, 0);
      check("rst_bus_in", bus_in, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("req_ready_idle", req_ready, 1);

      // word + low-byte read, word write
      run_txn(2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd3, 16'hBEEF, 0, 0, 0);
      // high-byte read on port 1 only, high-byte write
      run_txn(2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 16'h0077, 0, 0, 0);
      // no reads, no write
      run_txn(2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 16'h1111, 0, 0, 0);
      // stalled ALU on both handshakes
      run_txn(2'd1, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 16'h00AA, 5, 4, 0);
      // reset during WRITE, then during READ, then a clean request
      run_txn(2'd1, 2'd3, 2'd1, 2'd2, 2'd1, 2'd3, 16'hDEAD, 0, 0, 2);
      run_txn(2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 16'h9999, 0, 0, 1);
      run_txn(2'd3, 2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 16'h4242, 1, 1, 0);
      // write r2 then read it straight back on both ports
      run_txn(2'd0, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3, 16'h5555, 0, 0, 0);
      run_txn(2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 16'h0000, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         run_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_ops.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test by 400000ns, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/regfile_access_seq.md
Name: regfile_access_seq

Overview:
- Initiator side of the dual-read/single-write 4-entry double-register file port.
- Accepts one operand-fetch/writeback request from the control unit.
- Drives num1/num2 and exactly one cs_* strobe per port, then captures the registered read data and presents operands to the ALU with a valid/ready handshake.
- Accepts the ALU result and writes it back through port 1.

Parameters:
- ADDR_W, 2, register index width (drives num1/num2).
- DATA_W, 16, bus width; the byte lane is DATA_W/2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  high only in IDLE.
- src1, src2  in  ADDR_W  source register indices.
- mode1, mode2  in  2  read mode per port: 00 none, 01 low byte, 10 high byte, 11 word.
- dst  in  ADDR_W  destination register index.
- wmode  in  2  write mode; same encoding as mode1/mode2.
- op_valid  out  1  operands presented.
- op_ready  in  1  ALU accepts operands.
- op_a, op_b  out  DATA_W  captured operands.
- res_valid  in  1  result offered.
- res_ready  out  1  high only in RESULT.
- res_data  in  DATA_W  result.
- done  out  1  one-cycle completion strobe.
- num1, num2  out  ADDR_W  register file indices.
- bus_in  out  DATA_W  register file write data.
- bus_out1, bus_out2  in  DATA_W  register file registered read data.
- cs_h_out1, cs_l_out1, cs_16_out1  out  1  port-1 read strobes.
- cs_h_out2, cs_l_out2, cs_16_out2  out  1  port-2 read strobes.
- cs_h_in, cs_l_in, cs_16_in  out  1  write strobes.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All cs_* = 0; op_valid, res_ready, done = 0.
  - op_a = op_b = 0; num1 = num2 = 0; bus_in = 0; latched request fields = 0.
- Strobes decode combinationally from state and the latched request, so reset mid-operation deasserts them immediately. No partial write is ever issued.
- States: IDLE, READ, CAPTURE, OPS, RESULT, WRITE.
- IDLE:
  - req_ready = 1. On req_valid, latch src1/src2/mode1/mode2/dst/wmode.
  - Next state is READ. If mode1 = mode2 = 00, go straight to OPS with op_a = op_b = 0.
- READ (1 cycle):
  - num1 = src1, num2 = src2.
  - Assert exactly one strobe per port from its mode: 01 → cs_l, 10 → cs_h, 11 → cs_16, 00 → none.
  - Never assert more than one strobe per port; the register file prioritises h over l over 16.
- CAPTURE (1 cycle):
  - Register file output is valid this cycle. Hold num1/num2.
  - Register op_a ← bus_out1 if mode1 ≠ 00, else 0. Same rule for op_b from bus_out2/mode2. Undriven (z) buses are never sampled.
  - Byte reads arrive zero-extended in [7:0] and are passed through unmodified.
- Read latency: operands are valid in OPS, 3 cycles after the accept edge.
- OPS:
  - op_valid = 1; operands held stable until the op_valid && op_ready edge, then go to RESULT.
  - op_ready low means stay in OPS indefinitely.
- RESULT:
  - res_ready = 1. On res_valid, latch res_data into bus_in.
  - If wmode = 00: done = 1 this cycle, next state IDLE. Otherwise next state WRITE.
- WRITE (1 cycle):
  - num1 = dst; bus_in holds the latched result.
  - Strobe from wmode: 01 → cs_l_in, 10 → cs_h_in, 11 → cs_16_in.
  - done = 1 this cycle. Next state IDLE.
- Byte-write convention: the byte to write is at bus_in[7:0] for both h and l modes. The sequencer passes res_data through as-is; the ALU aligns the byte.
- Hazards:
  - Write commits on the WRITE→IDLE edge. The earliest following READ is 2 cycles later, so read-after-write is always safe.
  - src1 = src2 is legal; both ports read the same entry.
  - dst equal to a source is legal; the write occurs after capture.
- Handshake inputs (req_valid, op_ready, res_valid) are ignored outside their owning state.

Decomposition:
- Shared package holds:
  - mode encoding constants MODE_NONE/LOW/HIGH/WORD;
  - the state enum;
  - function mode_to_cs(mode) returning the {h, l, 16} strobe triple.
- A natural sub-module is regfile_strobe_dec, a combinational decode of (enable, mode) to a one-hot strobe triple. It is instantiated three times: port 1, port 2, write.

Test Plan:
- Preload r1 = 0x12_34, r2 = 0xAB_CD. Request src1=1 mode1=11, src2=2 mode2=01, dst=3 wmode=11; ALU returns 0xBEEF → op_a = 0x1234, op_b = 0x00CD in OPS (3 cycles after accept); cs_16_in with num1=3 one cycle after res handshake; r3 = 0xBEEF; done pulses once.
- mode1=10 on r1 = 0x1234, wmode=10 dst=0, res_data = 0x0077 → op_a = 0x0012; only cs_h_out1 and cs_h_in ever asserted; r0 high byte = 0x77, low byte unchanged.
- mode1 = mode2 = 00, wmode = 00 → no cs_* strobe ever asserted; op_a = op_b = 0; done asserted in the RESULT cycle.
- op_ready held low 5 cycles, res_valid delayed 4 cycles → operands stable throughout; no write strobe before the result; req_ready stays low.
- Assert reset during WRITE, and separately during READ → all cs_* drop in the same cycle; target register unchanged; after release, req_ready = 1 and a new request completes correctly.
- Back-to-back requests: write r2 = 0x5555, then immediately read r2 → second op_a = 0x5555, confirming read-after-write safety.
